// File: rtl/swivm_bus_responder.sv
// SwiVM CPU memory-bus slave: byte-lane RAM plus a 16-byte I/O window holding a
// console TX FIFO, an 8N1 serial transmitter, a status register and a cycle counter.
module swivm_bus_responder #(
    parameter int unsigned       ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] IO_BASE      = 16'hE000,
    parameter int unsigned       FIFO_DEPTH   = 8,
    parameter int unsigned       CLKS_PER_BIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wrdata,
    input  logic [1:0]        i_size,
    input  logic              i_we,
    output logic [31:0]       o_rddata,
    output logic              o_tx,
    output logic              o_err
);

    localparam int unsigned MemWords = 2 ** (ADDR_W - 2);
    localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW     = PtrW + 1;
    localparam int unsigned BaudW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzRsvd = 2'b01;
    localparam logic [1:0] SzHalf = 2'b10;
    localparam logic [1:0] SzWord = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

    // Storage
    logic [31:0]       r_mem  [MemWords];
    logic [7:0]        r_fifo [FIFO_DEPTH];

    // Control state
    logic [PtrW-1:0]   r_wptr;
    logic [PtrW-1:0]   r_rptr;
    logic [CntW-1:0]   r_count;
    logic              r_ovf;
    logic              r_err;
    logic [31:0]       r_cycles;

    tx_state_e         r_state;
    tx_state_e         w_state_d;
    logic [BaudW-1:0]  r_baud;
    logic [BaudW-1:0]  w_baud_d;
    logic [2:0]        r_bit;
    logic [2:0]        w_bit_d;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_d;

    // Decode and datapath wires
    logic              w_is_io;
    logic              w_rsvd;
    logic              w_wr;
    logic [1:0]        w_io_sel;
    logic              w_ram_we;
    logic              w_push;
    logic              w_push_acc;
    logic              w_pop;
    logic              w_ovf_clr;
    logic              w_err_set;
    logic              w_full;
    logic              w_empty;
    logic              w_busy;
    logic              w_tick;
    logic [3:0]        w_cnt4;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata_rep;
    logic [ADDR_W-3:0] w_word_idx;
    logic [31:0]       w_ram_word;
    logic [31:0]       w_io_word;
    logic [31:0]       w_src;

    assign w_is_io    = (i_addr[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]);
    assign w_rsvd     = (i_size == SzRsvd);
    assign w_wr       = ~i_we;
    assign w_io_sel   = i_addr[3:2];
    assign w_word_idx = i_addr[ADDR_W-1:2];

    // A reserved size suppresses every write side effect, RAM or I/O.
    assign w_ram_we  = w_wr && !w_is_io && !w_rsvd;
    assign w_push    = w_wr && w_is_io && !w_rsvd && (w_io_sel == 2'd0);
    assign w_ovf_clr = w_wr && w_is_io && !w_rsvd && (w_io_sel == 2'd1) && i_wrdata[3];
    assign w_err_set = w_wr && (w_rsvd || (w_is_io && (w_io_sel == 2'd3)));

    assign w_full     = (r_count == CntW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push_acc = w_push && (!w_full || w_pop);
    assign w_busy     = (r_state != StIdle);
    assign w_tick     = (r_baud == BaudW'(CLKS_PER_BIT - 1));
    assign w_cnt4     = 4'(r_count);

    // Write lane steering: replicate the LSB-justified data across lanes, enable by size.
    always_comb begin
        w_be        = 4'b0000;
        w_wdata_rep = i_wrdata;
        case (i_size)
            SzWord: w_be = 4'b1111;
            SzHalf: begin
                w_be        = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{i_wrdata[15:0]}};
            end
            SzByte: begin
                w_be        = 4'b0001 << i_addr[1:0];
                w_wdata_rep = {4{i_wrdata[7:0]}};
            end
            default: w_be = 4'b0000;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_word_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_acc) begin
            r_fifo[r_wptr] <= i_wrdata[7:0];
        end
    end

    assign w_ram_word = r_mem[w_word_idx];

    always_comb begin
        w_io_word = '0;
        case (w_io_sel)
            2'd1:    w_io_word = {24'h0, w_cnt4, r_ovf, w_busy, w_empty, w_full};
            2'd2:    w_io_word = r_cycles;
            default: w_io_word = '0;
        endcase
    end

    assign w_src = w_is_io ? w_io_word : w_ram_word;

    // Zero-extended little-endian lane extraction; reserved size reads as zero.
    always_comb begin
        o_rddata = '0;
        case (i_size)
            SzWord: o_rddata = w_src;
            SzHalf: o_rddata = {16'h0, (i_addr[1] ? w_src[31:16] : w_src[15:0])};
            SzByte: begin
                case (i_addr[1:0])
                    2'd0:    o_rddata = {24'h0, w_src[7:0]};
                    2'd1:    o_rddata = {24'h0, w_src[15:8]};
                    2'd2:    o_rddata = {24'h0, w_src[23:16]};
                    default: o_rddata = {24'h0, w_src[31:24]};
                endcase
            end
            default: o_rddata = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
            r_cycles <= '0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
            if (w_push_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push_acc, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_d;
            r_baud  <= w_baud_d;
            r_bit   <= w_bit_d;
            r_shift <= w_shift_d;
        end
    end

    // STOP chains straight into START when more data is queued, so frames are gap-free.
    always_comb begin
        w_state_d = r_state;
        w_baud_d  = r_baud;
        w_bit_d   = r_bit;
        w_shift_d = r_shift;
        w_pop     = 1'b0;
        case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_shift_d = r_fifo[r_rptr];
                    w_baud_d  = '0;
                    w_state_d = StStart;
                end
            end
            StStart: begin
                if (w_tick) begin
                    w_baud_d  = '0;
                    w_bit_d   = '0;
                    w_state_d = StData;
                end else begin
                    w_baud_d = r_baud + 1'b1;
                end
            end
            StData: begin
                if (w_tick) begin
                    w_baud_d = '0;
                    if (r_bit == 3'd7) begin
                        w_state_d = StStop;
                    end else begin
                        w_bit_d   = r_bit + 3'd1;
                        w_shift_d = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_baud_d = r_baud + 1'b1;
                end
            end
            default: begin
                if (w_tick) begin
                    w_baud_d = '0;
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_shift_d = r_fifo[r_rptr];
                        w_state_d = StStart;
                    end else begin
                        w_state_d = StIdle;
                    end
                end else begin
                    w_baud_d = r_baud + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        o_tx = 1'b1;
        case (r_state)
            StStart: o_tx = 1'b0;
            StData:  o_tx = r_shift[0];
            default: o_tx = 1'b1;
        endcase
    end

    assign o_err = r_err;

endmodule

// File: tb/tb_swivm_bus_responder.sv
// Scoreboard bench for swivm_bus_responder: bus probes and serial frames are queued
// by the stimulus and checked by independent negedge monitors.
module tb_swivm_bus_responder;

    localparam logic [15:0] IoTx   = 16'hE000;
    localparam logic [15:0] IoStat = 16'hE004;
    localparam logic [15:0] IoCyc  = 16'hE008;
    localparam logic [15:0] IoUnm  = 16'hE00C;
    localparam logic [1:0]  SzB    = 2'b00;
    localparam logic [1:0]  SzR    = 2'b01;
    localparam logic [1:0]  SzH    = 2'b10;
    localparam logic [1:0]  SzW    = 2'b11;

    logic        i_clk;
    logic        i_rst_n;
    logic [15:0] i_addr;
    logic [31:0] i_wrdata;
    logic [1:0]  i_size;
    logic        i_we;
    logic [31:0] o_rddata;
    logic        o_tx;
    logic        o_err;

    swivm_bus_responder #(
        .ADDR_W      (16),
        .IO_BASE     (16'hE000),
        .FIFO_DEPTH  (8),
        .CLKS_PER_BIT(4)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_addr  (i_addr),
        .i_wrdata(i_wrdata),
        .i_size  (i_size),
        .i_we    (i_we),
        .o_rddata(o_rddata),
        .o_tx    (o_tx),
        .o_err   (o_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Probe scoreboard: kind 0 = o_rddata, 1 = o_err, 2 = o_tx
    int          q_kind [$];
    logic [31:0] q_exp  [$];
    string       q_name [$];
    logic        obs_req = 1'b0;

    // Serial frame scoreboard
    logic [7:0]  q_tx [$];
    logic        mon_en = 1'b0;
    logic        m_gap  = 1'b0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          ob_k;
    logic [31:0] ob_e;
    logic [31:0] ob_act;
    string       ob_nm;

    initial begin
        forever begin
            @(negedge i_clk);
            if (obs_req) begin
                n_tests++;
                if (q_kind.size() == 0) begin
                    n_fail++;
                    $display("FAIL probe_queue: got an empty queue, required an entry");
                end else begin
                    ob_k   = q_kind.pop_front();
                    ob_e   = q_exp.pop_front();
                    ob_nm  = q_name.pop_front();
                    ob_act = (ob_k == 0) ? o_rddata : (ob_k == 1) ? {31'd0, o_err} : {31'd0, o_tx};
                    if (ob_act !== ob_e) begin
                        n_fail++;
                        $display("FAIL %s: got 0x%08h required 0x%08h", ob_nm, ob_act, ob_e);
                    end
                end
            end
        end
    end

    // Frame decoder: 40 samples per frame (start, 8 data, stop, 4 samples each).
    int         n_neg = 0;
    logic       m_act = 1'b0;
    int         m_pos;
    int         m_bitn;
    logic       m_ok;
    logic [7:0] m_byte;
    logic [7:0] m_exp;
    logic       m_have_end = 1'b0;
    int         m_end_neg;

    initial begin
        forever begin
            @(negedge i_clk);
            n_neg++;
            if (!m_gap) m_have_end = 1'b0;
            if (!i_rst_n || !mon_en) begin
                m_act      = 1'b0;
                m_have_end = 1'b0;
            end else if (!m_act) begin
                if (o_tx == 1'b0) begin
                    m_act  = 1'b1;
                    m_pos  = 1;
                    m_ok   = 1'b1;
                    m_byte = 8'h00;
                    if (m_gap && m_have_end) begin
                        n_tests++;
                        if (n_neg != m_end_neg + 1) begin
                            n_fail++;
                            $display("FAIL frame_gap: got start at sample %0d required %0d",
                                     n_neg, m_end_neg + 1);
                        end
                    end
                end
            end else begin
                m_bitn = m_pos / 4;
                if (m_bitn == 0) begin
                    if (o_tx !== 1'b0) m_ok = 1'b0;
                end else if (m_bitn <= 8) begin
                    if (m_pos % 4 == 0) m_byte[m_bitn-1] = o_tx;
                    else if (o_tx !== m_byte[m_bitn-1]) m_ok = 1'b0;
                end else begin
                    if (o_tx !== 1'b1) m_ok = 1'b0;
                end
                if (m_pos == 39) begin
                    n_tests++;
                    if (q_tx.size() == 0) begin
                        n_fail++;
                        $display("FAIL frame_extra: got byte 0x%02h, required no frame", m_byte);
                    end else begin
                        m_exp = q_tx.pop_front();
                        if (!m_ok || m_byte !== m_exp) begin
                            n_fail++;
                            $display("FAIL frame: got byte 0x%02h shape_ok=%0b required 0x%02h",
                                     m_byte, m_ok, m_exp);
                        end
                    end
                    m_act      = 1'b0;
                    m_have_end = 1'b1;
                    m_end_neg  = n_neg;
                end else begin
                    m_pos++;
                end
            end
        end
    end

    task automatic obs(input int kind, input logic [31:0] exp, input string name);
        q_kind.push_back(kind);
        q_exp.push_back(exp);
        q_name.push_back(name);
        obs_req = 1'b1;
        @(posedge i_clk);
        #1;
        obs_req = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a, input logic [1:0] s, input logic [31:0] exp,
                          input string name);
        i_addr = a;
        i_size = s;
        i_we   = 1'b1;
        obs(0, exp, name);
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [31:0] d, input logic [1:0] s);
        i_addr   = a;
        i_wrdata = d;
        i_size   = s;
        i_we     = 1'b0;
        @(posedge i_clk);
        #1;
        i_we = 1'b1;
    endtask

    initial begin
        i_rst_n  = 1'b0;
        i_addr   = 16'h0000;
        i_wrdata = 32'h0;
        i_size   = SzW;
        i_we     = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        obs(2, 32'd1, "reset_tx");
        obs(1, 32'd0, "reset_err");
        i_rst_n = 1'b1;
        bus_rd(IoCyc, SzW, 32'd0, "cycles_start0");
        bus_rd(IoCyc, SzW, 32'd1, "cycles_start1");
        bus_rd(IoStat, SzW, 32'h2, "status_reset");
        mon_en = 1'b1;

        // RAM lanes
        bus_wr(16'h0100, 32'hDEADBEEF, SzW);
        bus_rd(16'h0100, SzW, 32'hDEADBEEF, "word_rd");
        bus_rd(16'h0103, SzW, 32'hDEADBEEF, "word_rd_unaligned");
        bus_wr(16'h0102, 32'hFFFFFF55, SzB);
        bus_rd(16'h0100, SzW, 32'hDE55BEEF, "byte_merge");
        bus_rd(16'h0102, SzH, 32'h0000DE55, "half_rd_hi");
        bus_rd(16'h0103, SzB, 32'h000000DE, "byte_rd_3");
        bus_rd(16'h0100, SzH, 32'h0000BEEF, "half_rd_lo");
        bus_rd(16'h0101, SzB, 32'h000000BE, "byte_rd_1");
        bus_wr(16'h0200, 32'h11223344, SzW);
        bus_wr(16'h0202, 32'hFFFF9876, SzH);
        bus_rd(16'h0200, SzW, 32'h98763344, "half_merge");

        // Unmapped I/O slot
        bus_rd(IoUnm, SzW, 32'h0, "unmapped_rd");
        obs(1, 32'd0, "err_after_unmapped_rd");
        bus_rd(IoTx, SzW, 32'h0, "txdata_rd");
        bus_wr(IoUnm, 32'hFFFFFFFF, SzW);
        obs(1, 32'd1, "err_unmapped_wr");

        // Single frame, word-size write carries only the low byte
        bus_wr(IoTx, 32'hABCDEF41, SzW);
        q_tx.push_back(8'h41);
        obs(2, 32'd1, "tx_idle_push_cycle");
        obs(2, 32'd0, "tx_start_latency");
        bus_rd(IoStat, SzW, 32'h6, "status_busy");
        repeat (40) @(posedge i_clk);
        #1;
        bus_rd(IoStat, SzW, 32'h2, "status_done");

        // Burst: b0 is popped at once, b1..b8 fill the FIFO, b9 is dropped
        m_gap = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus_wr(IoTx, 32'h30 + i, SzB);
            if (i < 9) q_tx.push_back(8'h30 + 8'(i));
        end
        bus_rd(IoStat, SzW, 32'h8D, "status_full_ovf");
        bus_wr(IoStat, 32'h8, SzW);
        bus_rd(IoStat, SzW, 32'h85, "status_ovf_clr");
        // Land a push on the edge where STOP of the first frame pops
        repeat (28) @(posedge i_clk);
        #1;
        bus_wr(IoTx, 32'h6A, SzB);
        q_tx.push_back(8'h6A);
        bus_rd(IoStat, SzW, 32'h85, "push_with_pop");
        bus_wr(IoTx, 32'h6B, SzB);
        bus_rd(IoStat, SzW, 32'h8D, "push_full_drop");
        bus_wr(IoStat, 32'h8, SzW);
        repeat (360) @(posedge i_clk);
        #1;
        bus_rd(IoStat, SzW, 32'h2, "status_burst_done");
        m_gap = 1'b0;
        obs(1, 32'd1, "err_sticky");

        // Reset in the middle of data bit 3 of 0x41 (a 0 bit)
        mon_en = 1'b0;
        bus_wr(IoTx, 32'h41, SzB);
        bus_wr(IoTx, 32'h77, SzB);
        repeat (17) @(posedge i_clk);
        #1;
        obs(2, 32'd0, "tx_bit3_low");
        i_rst_n = 1'b0;
        obs(2, 32'd1, "tx_reset_abort");
        obs(1, 32'd0, "err_reset_clear");
        i_rst_n = 1'b1;
        bus_rd(IoCyc, SzW, 32'd0, "cycles_restart0");
        bus_rd(IoCyc, SzW, 32'd1, "cycles_restart1");
        bus_rd(IoStat, SzW, 32'h2, "status_after_reset");
        obs(2, 32'd1, "tx_idle_after_reset");

        // Reserved size
        bus_wr(16'h0100, 32'h12345678, SzR);
        bus_rd(16'h0100, SzW, 32'hDE55BEEF, "rsvd_wr_ignored");
        obs(1, 32'd1, "err_rsvd_wr");
        bus_rd(16'h0100, SzR, 32'h0, "rsvd_rd_zero");
        repeat (3) @(posedge i_clk);
        #1;
        obs(1, 32'd1, "err_rsvd_sticky");

        repeat (2) @(posedge i_clk);
        #1;
        n_tests++;
        if (q_tx.size() != 0) begin
            n_fail++;
            $display("FAIL frames_outstanding: got %0d frames missing, required 0", q_tx.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/swivm_bus_responder.md
Name: swivm_bus_responder

Overview:
- Slave end of the SwiVM CPU memory bus: services the CPU's combinational-read, write-on-clock protocol.
- Provides word-organised RAM with byte, halfword and word lanes.
- Provides a small memory-mapped I/O window: console transmit FIFO, serial 8N1 transmitter, status register and free-running cycle counter.
- Instantiated beside the CPU core; replaces direct RAM hookup in the system top.

Parameters:
- ADDR_W, 16, byte-address width of the bus; RAM depth is 2**(ADDR_W-2) words.
- IO_BASE, 16'hE000, base of the 16-byte I/O window. Must be 16-byte aligned. Accesses inside the window never touch RAM.
- FIFO_DEPTH, 8, TX FIFO entries. Must be a power of two.
- CLKS_PER_BIT, 4, clock cycles per serial bit. Minimum 2.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_addr  input  ADDR_W  byte address from CPU.
- i_wrdata  input  32  write data; active lanes are LSB-justified.
- i_size  input  2  transfer size: 11 word, 10 halfword, 00 byte, 01 reserved.
- i_we  input  1  active-low write enable. 0 means write at this edge; 1 means read.
- o_rddata  output  32  read data, combinational from i_addr/i_size.
- o_tx  output  1  serial transmit line; idles high.
- o_err  output  1  sticky flag for a reserved size or an unmapped I/O access.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - o_tx=1, o_err=0.
  - FIFO empty, TX FSM IDLE, overflow=0, cycle counter=0.
  - RAM contents are not cleared.
- Read timing:
  - o_rddata is valid in the same cycle i_addr/i_size change, with zero wait states.
  - The CPU samples it at the following edge.
- Write timing: commits on every rising edge where i_we=0. Writes repeat harmlessly if i_we is held low.
- Byte ordering is little-endian.
  - Word: addr[1:0] ignored.
  - Halfword: addr[1] selects lane [15:0] or [31:16]; addr[0] ignored.
  - Byte: addr[1:0] selects the lane.
- Sub-word reads are zero-extended. Sub-word writes take i_wrdata[7:0] or [15:0] and leave the other lanes unchanged.
- Reserved size 01:
  - Reads return 0.
  - Writes are ignored and set o_err.
- I/O window (offset = addr - IO_BASE, word-decoded on offset[3:2]):
  - +0 TXDATA:
    - Write pushes i_wrdata[7:0] regardless of size.
    - Read returns 0.
  - +4 STATUS (read): bit0 full, bit1 empty, bit2 tx_busy, bit3 overflow, bits[7:4] FIFO count, other bits 0.
    - Write with i_wrdata[3]=1 clears overflow.
  - +8 CYCLES: read-only 32-bit free-running counter, wraps at 2**32. Writes are ignored.
  - +C: unmapped.
    - Read returns 0.
    - Any write sets o_err.
    - A read does not set o_err.
- FIFO push rules:
  - A push while full is dropped and sets overflow.
  - Exception: if the TX FSM pops in the same cycle, the push is accepted.
  - Count saturates at FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO is non-empty at an edge, pop, load the shift register and enter START. o_tx goes 0 from that edge.
  - Each bit lasts CLKS_PER_BIT cycles.
  - DATA sends 8 bits, LSB first.
  - STOP drives 1.
  - At the end of STOP: if FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
  - tx_busy = state != IDLE.
- Latency: a push to an empty FIFO with IDLE FSM gives a start bit 1 cycle after the push edge.
- Reset mid-frame aborts the frame immediately: o_tx=1, FIFO contents discarded.
- o_err clears only on reset.

Test Plan:
- Word write 0xDEADBEEF @0x0100, then word read @0x0100 -> o_rddata=0xDEADBEEF. Word read @0x0103 -> same value.
- Byte write 0x55 @0x0102 over 0xDEADBEEF -> word read 0xDE55BEEF. Half read @0x0102 -> 0x0000DE55. Byte read @0x0103 -> 0x000000DE.
- CLKS_PER_BIT=4, write 0x41 to TXDATA with FIFO empty:
  - o_tx low for 4 cycles starting 1 cycle after the edge.
  - Then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then high for 4.
  - Total 40 cycles.
  - tx_busy reads 1 during the frame and 0 after.
- 10 back-to-back TXDATA writes while transmitting:
  - The FIFO fills to 8 (STATUS[7:4]=8, bit0=1); later writes are dropped and set overflow (bit3=1).
  - Frames go out gap-free.
  - Writing 0x8 to STATUS clears overflow.
- Pull i_rst_n low mid-DATA bit 3 -> o_tx=1 immediately, STATUS reads empty=1, count=0, CYCLES restarts from 0.
- Write with size 01 @0x0100 -> RAM unchanged, o_err=1 and stays set. Write @IO_BASE+0xC -> o_err=1. Read @IO_BASE+0xC -> 0.
